// File: rtl/pmem_line_adapter.sv
// Cache-line (256-bit) to 64-bit burst memory adapter; responder side of the arbiter pmem port.
// Optional critical-word-first ordering is enabled by defining PMEM_WRAP_BURST_EN.
module pmem_line_adapter #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pmem_read,
    input  logic                      pmem_write,
    input  logic [31:0]               pmem_address,
    input  logic [BEAT_W*BEATS-1:0]   pmem_wdata,
    output logic                      pmem_resp,
    output logic [BEAT_W*BEATS-1:0]   pmem_rdata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [31:0]               mem_address,
    output logic [BEAT_W-1:0]         mem_wdata,
    input  logic [BEAT_W-1:0]         mem_rdata,
    input  logic                      mem_resp
);

    localparam int IDX_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEAT_W / 8);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] start_idx;
    logic             start_wr;
    logic             rd_beat;
    logic             rd_last;
    logic             unused_addr_bits;

    logic [BEATS-1:0][BEAT_W-1:0] line_vec;
    logic [BEATS-1:0][BEAT_W-1:0] rdata_vec;

`ifdef PMEM_WRAP_BURST_EN
    assign start_idx = pmem_address[OFF_W +: IDX_W];
`else
    assign start_idx = '0;
`endif
    assign unused_addr_bits = ^pmem_address[OFF_W+IDX_W-1:0];

    assign start_wr = (state_q == S_IDLE) && pmem_write;
    assign rd_beat  = (state_q == S_RD) && mem_resp;
    assign rd_last  = rd_beat && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (pmem_write || pmem_read) begin
                    tag_d   = pmem_address[31 -: TAG_W];
                    idx_d   = start_idx;
                    cnt_d   = '0;
                    state_d = pmem_write ? S_WR : S_RD;
                end
            end
            S_RD, S_WR: begin
                // idx wraps freely; only the separate beat count ends the burst
                if (mem_resp) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    // One slot per beat: holds the write line, or assembles read beats before
    // the completed line is copied to the visible read register.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BEAT_W-1:0] line_q, line_d;
            logic [BEAT_W-1:0] rdata_q;
            logic              slot_hit;

            assign slot_hit = rd_beat && (idx_q == IDX_W'(gi));
            assign line_d   = start_wr ? pmem_wdata[gi*BEAT_W +: BEAT_W] :
                              slot_hit ? mem_rdata : line_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    line_q  <= '0;
                    rdata_q <= '0;
                end else begin
                    line_q <= line_d;
                    if (rd_last) begin
                        rdata_q <= line_d;
                    end
                end
            end

            assign line_vec[gi]  = line_q;
            assign rdata_vec[gi] = rdata_q;
        end
    endgenerate

    assign mem_read    = (state_q == S_RD);
    assign mem_write   = (state_q == S_WR);
    assign pmem_resp   = (state_q == S_DONE);
    assign mem_address = {tag_q, idx_q, {OFF_W{1'b0}}};
    assign mem_wdata   = line_vec[idx_q];
    assign pmem_rdata  = rdata_vec;

endmodule
